// File: rtl/div_issue_ctrl_if.sv
// Operand and result handshake bundle for div_issue_ctrl.
// The slave side is the controller; the master side is the operand producer / result consumer.
interface div_issue_ctrl_if #(
  parameter int DW = 6,
  parameter int VW = 3,
  parameter int QW = 4
);
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_dividend;
  logic [VW-1:0] in_divisor;
  logic          out_valid;
  logic          out_ready;
  logic [QW-1:0] out_quot;
  logic [QW-1:0] out_rem;
  logic          out_dbz;
  logic          out_ovf;

  modport slave (
    input  in_valid, in_dividend, in_divisor, out_ready,
    output in_ready, out_valid, out_quot, out_rem, out_dbz, out_ovf
  );

  modport master (
    output in_valid, in_dividend, in_divisor, out_ready,
    input  in_ready, out_valid, out_quot, out_rem, out_dbz, out_ovf
  );
endinterface

// File: rtl/div_issue_ctrl.sv
// Issue/capture controller around a combinational restoring divider array:
// screens divide-by-zero and quotient overflow, holds operands SETTLE cycles, then captures the result.
module div_issue_ctrl #(
  parameter int DW     = 6,
  parameter int VW     = 3,
  parameter int QW     = 4,
  parameter int SETTLE = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  div_issue_ctrl_if.slave bus,
  output logic [DW-1:0]   div_R_0,
  output logic [VW-1:0]   div_D,
  input  logic [QW-1:0]   div_Q,
  input  logic [QW-1:0]   div_R_n1
);
  localparam logic [3:0] CNT_INIT = 4'(SETTLE - 1);

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_HOLD} state_t;

  state_t        r_state;
  state_t        w_next;
  logic [3:0]    r_cnt;
  logic [DW-1:0] r_R0;
  logic [VW-1:0] r_D;
  logic [QW-1:0] r_quot;
  logic [QW-1:0] r_rem;
  logic          r_dbz;
  logic          r_ovf;
  logic          w_accept;
  logic          w_dbz;
  logic          w_ovf;

  // Quotient fits in QW bits only when dividend < divisor * 2^QW.
  function automatic logic f_quot_ovf(input logic [DW-1:0] dvd, input logic [VW-1:0] dvs);
    logic [DW:0] lim;
    lim = (DW+1)'({dvs, {QW{1'b0}}});
    return ({1'b0, dvd} >= lim);
  endfunction

  assign w_dbz = (bus.in_divisor == '0);
  assign w_ovf = f_quot_ovf(bus.in_dividend, bus.in_divisor);

  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (bus.in_valid) begin
          w_accept = 1'b1;
          w_next   = (w_dbz || w_ovf) ? S_HOLD : S_SETTLE;
        end
      end
      S_SETTLE: if (r_cnt == 4'd0) w_next = S_HOLD;
      S_HOLD:   if (bus.out_ready) w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_R0    <= '0;
      r_D     <= '0;
      r_quot  <= '0;
      r_rem   <= '0;
      r_dbz   <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_R0 <= bus.in_dividend;
        r_D  <= bus.in_divisor;
        // Error results bypass the array entirely; dbz wins over ovf.
        if (w_dbz) begin
          r_quot <= '1;
          r_rem  <= bus.in_dividend[QW-1:0];
          r_dbz  <= 1'b1;
          r_ovf  <= 1'b0;
        end else if (w_ovf) begin
          r_quot <= '1;
          r_rem  <= '0;
          r_dbz  <= 1'b0;
          r_ovf  <= 1'b1;
        end else begin
          r_cnt <= CNT_INIT;
        end
      end else if (r_state == S_SETTLE) begin
        if (r_cnt == 4'd0) begin
          r_quot <= div_Q;
          r_rem  <= div_R_n1;
          r_dbz  <= 1'b0;
          r_ovf  <= 1'b0;
        end else begin
          r_cnt <= r_cnt - 4'd1;
        end
      end
    end
  end

  assign bus.in_ready  = (r_state == S_IDLE);
  assign bus.out_valid = (r_state == S_HOLD);
  assign bus.out_quot  = r_quot;
  assign bus.out_rem   = r_rem;
  assign bus.out_dbz   = r_dbz;
  assign bus.out_ovf   = r_ovf;
  assign div_R_0       = r_R0;
  assign div_D         = r_D;
endmodule

// File: tb/tb_div_issue_ctrl.sv
// Self-checking bench for div_issue_ctrl: table-driven vectors through a scoreboard,
// plus backpressure and mid-SETTLE reset sequences on a second SETTLE=3 instance.
module tb_div_issue_ctrl;
  localparam int DW = 6, VW = 3, QW = 4;

  typedef struct {
    logic [DW-1:0] dvd;
    logic [VW-1:0] dvs;
    logic [QW-1:0] q;
    logic [QW-1:0] r;
    bit            dbz;
    bit            ovf;
    int            acc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rst2_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  div_issue_ctrl_if #(.DW(DW), .VW(VW), .QW(QW)) ifc ();
  div_issue_ctrl_if #(.DW(DW), .VW(VW), .QW(QW)) ifc2 ();

  logic [DW-1:0] r0_1, r0_2;
  logic [VW-1:0] d_1, d_2;
  logic [QW-1:0] q_1, rm_1, q_2, rm_2;

  div_issue_ctrl #(.DW(DW), .VW(VW), .QW(QW), .SETTLE(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .bus(ifc),
    .div_R_0(r0_1), .div_D(d_1), .div_Q(q_1), .div_R_n1(rm_1)
  );

  div_issue_ctrl #(.DW(DW), .VW(VW), .QW(QW), .SETTLE(3)) u_dut3 (
    .clk(clk), .rst_n(rst2_n), .bus(ifc2),
    .div_R_0(r0_2), .div_D(d_2), .div_Q(q_2), .div_R_n1(rm_2)
  );

  // Behavioural stand-in for the combinational divider array.
  function automatic logic [2*QW-1:0] f_array(input logic [DW-1:0] a, input logic [VW-1:0] b);
    logic [QW-1:0] q, r;
    q = '0;
    r = '0;
    if (b != '0) begin
      q = QW'(a / b);
      r = QW'(a % b);
    end
    return {q, r};
  endfunction

  always_comb {q_1, rm_1} = f_array(r0_1, d_1);
  always_comb {q_2, rm_2} = f_array(r0_2, d_2);

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  exp_t sb[$];
  exp_t cur_exp;
  exp_t head;
  bit   prev_v = 0, prev_rdy = 0, have_prev = 0, prev_err = 0;
  bit   chk_tput = 0, chk_bp_next = 0;
  int   prev_acc = 0, hs_cyc = 0, n_hs = 0, bp_cnt = 0;
  logic [QW-1:0] s_q, s_r;
  logic s_dbz, s_ovf;
  bit   watch2 = 0, seen_v2 = 0;

  // Scoreboard monitor for the SETTLE=1 instance, sampled on the falling edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (ifc.out_valid) begin
        if (!prev_v) begin
          if (sb.size() == 0) chk("unexpected_out_valid", 1, 0);
          else begin
            head = sb[0];
            chk("latency", cyc - head.acc, (head.dbz || head.ovf) ? 1 : 2);
            chk("quot", int'(ifc.out_quot), int'(head.q));
            chk("rem", int'(ifc.out_rem), int'(head.r));
            chk("dbz", int'(ifc.out_dbz), int'(head.dbz));
            chk("ovf", int'(ifc.out_ovf), int'(head.ovf));
            chk("div_R_0_held", int'(r0_1), int'(head.dvd));
            chk("div_D_held", int'(d_1), int'(head.dvs));
          end
          s_q = ifc.out_quot; s_r = ifc.out_rem; s_dbz = ifc.out_dbz; s_ovf = ifc.out_ovf;
        end else if (!prev_rdy) begin
          bp_cnt++;
          chk("bp_quot_stable", int'(ifc.out_quot), int'(s_q));
          chk("bp_rem_stable", int'(ifc.out_rem), int'(s_r));
          chk("bp_flags_stable", int'({ifc.out_dbz, ifc.out_ovf}), int'({s_dbz, s_ovf}));
          chk("bp_in_ready_low", int'(ifc.in_ready), 0);
        end
        if (ifc.out_ready) begin
          if (sb.size() != 0) void'(sb.pop_front());
          hs_cyc = cyc;
          n_hs++;
        end
      end
      if (ifc.in_valid && ifc.in_ready) begin
        if (chk_tput && have_prev) chk("throughput", cyc - prev_acc, prev_err ? 2 : 3);
        if (chk_bp_next) begin
          chk("accept_after_release", cyc - hs_cyc, 1);
          chk_bp_next = 0;
        end
        cur_exp.acc = cyc;
        sb.push_back(cur_exp);
        prev_acc  = cyc;
        prev_err  = cur_exp.dbz || cur_exp.ovf;
        have_prev = 1;
      end
      prev_v   = ifc.out_valid;
      prev_rdy = ifc.out_ready;
    end
    if (watch2 && ifc2.out_valid) seen_v2 = 1;
  end

  // Called at posedge+2; returns at posedge+2 after the accepting edge.
  task automatic send(input exp_t v);
    int n = 0;
    cur_exp = v;
    ifc.in_dividend = v.dvd;
    ifc.in_divisor  = v.dvs;
    ifc.in_valid    = 1'b1;
    @(negedge clk);
    while (!ifc.in_ready && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (n >= 64) chk("accept_timeout", 0, 1);
    @(posedge clk); #2;
    ifc.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 64) begin
      @(posedge clk); #2;
      n++;
    end
    if (n >= 64) chk("drain_timeout", 0, 1);
  endtask

  exp_t vec[13];
  exp_t bpv, nxt;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int a2;
    int hs0;
    vec[0]  = '{6'd45, 3'd5, 4'd9,  4'd0,  0, 0, 0};
    vec[1]  = '{6'd27, 3'd7, 4'd3,  4'd6,  0, 0, 0};
    vec[2]  = '{6'd47, 3'd3, 4'd15, 4'd2,  0, 0, 0};
    vec[3]  = '{6'd48, 3'd3, 4'hF,  4'd0,  0, 1, 0};
    vec[4]  = '{6'd63, 3'd1, 4'hF,  4'd0,  0, 1, 0};
    vec[5]  = '{6'd13, 3'd0, 4'hF,  4'hD,  1, 0, 0};
    vec[6]  = '{6'd0,  3'd7, 4'd0,  4'd0,  0, 0, 0};
    vec[7]  = '{6'd15, 3'd1, 4'd15, 4'd0,  0, 0, 0};
    vec[8]  = '{6'd16, 3'd1, 4'hF,  4'd0,  0, 1, 0};
    vec[9]  = '{6'd62, 3'd4, 4'd15, 4'd2,  0, 0, 0};
    vec[10] = '{6'd55, 3'd6, 4'd9,  4'd1,  0, 0, 0};
    vec[11] = '{6'd0,  3'd0, 4'hF,  4'd0,  1, 0, 0};
    vec[12] = '{6'd63, 3'd0, 4'hF,  4'hF,  1, 0, 0};

    ifc.in_valid = 0; ifc.in_dividend = '0; ifc.in_divisor = '0; ifc.out_ready = 1;
    ifc2.in_valid = 0; ifc2.in_dividend = '0; ifc2.in_divisor = '0; ifc2.out_ready = 1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", int'(ifc.in_ready), 1);
    chk("rst_out_valid", int'(ifc.out_valid), 0);
    chk("rst_quot", int'(ifc.out_quot), 0);
    chk("rst_rem", int'(ifc.out_rem), 0);
    chk("rst_flags", int'({ifc.out_dbz, ifc.out_ovf}), 0);
    chk("rst_div_R_0", int'(r0_1), 0);
    chk("rst_div_D", int'(d_1), 0);
    @(posedge clk); #2;
    rst_n = 1; rst2_n = 1;
    @(posedge clk); #2;

    // Back-to-back table with out_ready tied high.
    chk_tput = 1;
    foreach (vec[i]) send(vec[i]);
    drain();
    chk("table_handshakes", n_hs, 13);
    chk_tput = 0;

    // Backpressure on 27/7, with the next operand already waiting.
    bpv = '{6'd27, 3'd7, 4'd3, 4'd6, 0, 0, 0};
    nxt = '{6'd45, 3'd5, 4'd9, 4'd0, 0, 0, 0};
    @(posedge clk); #2;
    ifc.out_ready = 0;
    bp_cnt = 0;
    hs0 = n_hs;
    fork
      begin
        send(bpv);
        send(nxt);
      end
      begin
        n = 0;
        @(negedge clk);
        while (!ifc.out_valid && n < 32) begin
          @(negedge clk);
          n++;
        end
        if (n >= 32) chk("bp_valid_timeout", 0, 1);
        repeat (5) @(posedge clk);
        #2;
        chk_bp_next = 1;
        ifc.out_ready = 1;
      end
    join
    drain();
    chk("bp_hold_cycles", bp_cnt, 5);
    chk("bp_handshakes", n_hs - hs0, 2);

    // SETTLE=3 instance: normal latency, then reset mid-SETTLE.
    @(posedge clk); #2;
    ifc2.in_dividend = 6'd27; ifc2.in_divisor = 3'd7; ifc2.in_valid = 1;
    @(negedge clk);
    chk("s3_in_ready", int'(ifc2.in_ready), 1);
    a2 = cyc;
    @(posedge clk); #2;
    ifc2.in_valid = 0;
    n = 0;
    @(negedge clk);
    while (!ifc2.out_valid && n < 32) begin
      @(negedge clk);
      n++;
    end
    chk("s3_latency", cyc - a2, 4);
    chk("s3_quot", int'(ifc2.out_quot), 3);
    chk("s3_rem", int'(ifc2.out_rem), 6);
    @(posedge clk); #2;
    @(posedge clk); #2;
    ifc2.in_dividend = 6'd45; ifc2.in_divisor = 3'd5; ifc2.in_valid = 1;
    @(negedge clk);
    chk("s3_rst_pre_ready", int'(ifc2.in_ready), 1);
    seen_v2 = 0;
    watch2 = 1;
    @(posedge clk); #2;
    ifc2.in_valid = 0;
    @(posedge clk); #2;
    rst2_n = 0;
    @(posedge clk); #2;
    rst2_n = 1;
    @(negedge clk);
    chk("s3_rst_in_ready", int'(ifc2.in_ready), 1);
    chk("s3_rst_div_R_0", int'(r0_2), 0);
    chk("s3_rst_div_D", int'(d_2), 0);
    repeat (8) @(negedge clk);
    chk("s3_rst_no_valid", int'(seen_v2), 0);
    watch2 = 0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
